bsg_chip_router_reset_seq: RTL and testbench
============================================

BSG_CHIP_ROUTER_RESET_SEQ -- requirements
Module: bsg_chip_router_reset_seq

Interface
REQ-001 SHALL have parameter num_router_p, default 5: number of router reset outputs, at least 1.
REQ-002 SHALL have parameter cord_width_p, default 7: width of the wormhole cord.
REQ-003 SHALL have parameter min_reset_cycles_p, default 16: minimum cycles all resets are held, at least 1.
REQ-004 SHALL have parameter stagger_cycles_p, default 4: cycles between successive router releases, at least 1.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock (router clock); all logic is on its rising edge.
REQ-006 SHALL have port reset_n_i, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port req_v_i, input, 1 bit: single-cycle pulse for a new tag payload (the tag client's new-data strobe).
REQ-008 SHALL have port req_reset_i, input, 1 bit: requested reset level from the tag payload.
REQ-009 SHALL have port req_cord_i, input, cord_width_p bits: requested cord from the tag payload.
REQ-010 SHALL have port reset_o, output, num_router_p bits: per-router active-high reset.
REQ-011 SHALL have port cord_o, output, cord_width_p bits: latched cord.
REQ-012 SHALL have port done_o, output, 1 bit: all routers released.
REQ-013 SHALL have port busy_o, output, 1 bit: high when the state is not RUN.
REQ-014 All outputs SHALL be driven directly from flops.

Function
REQ-015 SHALL implement four states:
- HOLD: all reset_o high; the hold counter runs.
- WAIT: all reset_o high; waiting for a tag write with reset=0.
- STAGGER: routers released one at a time.
- RUN: all reset_o low.
REQ-016 SHALL hold an internal latched request bit, req_r.
REQ-017 A req_v_i with req_reset_i=1, in any state, SHALL on the next edge:
- set req_r=1;
- load cord_o from req_cord_i;
- drive all reset_o high;
- enter HOLD with the hold counter at 0.
REQ-018 A req_v_i with req_reset_i=0 in HOLD or WAIT SHALL set req_r=0 and load cord_o.
REQ-019 A req_v_i with req_reset_i=0 in STAGGER or RUN SHALL be ignored: cord_o, req_r and the state are unchanged.
REQ-020 HOLD SHALL last exactly min_reset_cycles_p cycles. When the hold counter equals min_reset_cycles_p-1, the next state SHALL be:
- WAIT if req_r=1;
- STAGGER if req_r=0, also counting a reset=0 request that arrives in that same final cycle.
REQ-021 In WAIT, a req_v_i with req_reset_i=0 SHALL move the state to STAGGER on the next edge.
REQ-022 On entry to STAGGER, the stagger counter SHALL be 0 and the router index SHALL be 0.
REQ-023 In STAGGER, each time the stagger counter equals stagger_cycles_p-1:
- reset_o[index] SHALL fall on the next edge;
- the index SHALL increment;
- the stagger counter SHALL clear.
REQ-024 Routers SHALL be released in ascending index order; a released bit SHALL stay low until the next HOLD.
REQ-025 When reset_o[num_router_p-1] falls, the state SHALL become RUN on the same edge, with done_o=1 and busy_o=0.
REQ-026 done_o SHALL be 1 only in RUN.
REQ-027 Counter widths SHALL be clog2 of the respective parameter, with a minimum of 1 bit. Counters SHALL NOT wrap, because each clears on exit from its state.
REQ-028 A reset=1 request mid-STAGGER SHALL re-assert every reset_o bit, including already-released bits, on the next edge.

Reset
REQ-029 While reset_n_i=0 on an edge, the block SHALL set:
- state=HOLD;
- hold counter=0, stagger counter=0, index=0;
- req_r=1;
- all reset_o=1;
- cord_o=0;
- done_o=0, busy_o=1.
REQ-030 reset_n_i=0 SHALL dominate any simultaneous req_v_i; that request is lost.

Verification
All timings below use default parameters. Cycle 0 is the first edge with reset_n_i=1.
REQ-031 Reset deasserts; req_v_i with reset=0 and cord=0x12 at cycle 2. Required response:
- cord_o=0x12 from cycle 3;
- HOLD during cycles 0-15;
- reset_o[k] falls at cycle 20+4k;
- done_o=1 from cycle 36.
REQ-032 No request after reset. Required response:
- WAIT from cycle 16 with reset_o=5'b11111 indefinitely;
- a reset=0 request at cycle 40 gives STAGGER at 41 and reset_o[0] low at 45.
REQ-033 In RUN, req_v_i with reset=1 and cord=0x05. Required response:
- next cycle reset_o=5'b11111, cord_o=0x05, done_o=0;
- HOLD lasts 16 cycles, then WAIT.
REQ-034 Mid-STAGGER, after reset_o[1] falls, a reset=1 request. Required response:
- all bits high next cycle;
- the sequence restarts from HOLD.
REQ-035 In RUN, a reset=0 request with cord=0x33. Required response: cord_o, reset_o and done_o unchanged.
REQ-036 req_v_i with reset=0 in the same cycle reset_n_i=0. Required response: the request is dropped, req_r=1, and after release the block goes to WAIT.

Source files
------------

// File: rtl/bsg_chip_router_reset_seq.sv
// ============================================================================
//  Module      : bsg_chip_router_reset_seq
//  Description : Tag-driven router reset sequencer. Holds every router in
//                reset for a minimum time, then releases them one at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_chip_router_reset_seq #(
    parameter int num_router_p       = 5,
    parameter int cord_width_p       = 7,
    parameter int min_reset_cycles_p = 16,
    parameter int stagger_cycles_p   = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    req_v_i,
    input  logic                    req_reset_i,
    input  logic [cord_width_p-1:0] req_cord_i,
    output logic [num_router_p-1:0] reset_o,
    output logic [cord_width_p-1:0] cord_o,
    output logic                    done_o,
    output logic                    busy_o
);

    localparam int c_hold_w = (min_reset_cycles_p > 1) ? $clog2(min_reset_cycles_p) : 1;
    localparam int c_stag_w = (stagger_cycles_p > 1)   ? $clog2(stagger_cycles_p)   : 1;
    localparam int c_idx_w  = (num_router_p > 1)       ? $clog2(num_router_p)       : 1;

    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(min_reset_cycles_p - 1);
    localparam logic [c_stag_w-1:0] c_stag_last = c_stag_w'(stagger_cycles_p - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(num_router_p - 1);

    localparam logic [1:0] c_st_hold    = 2'd0;
    localparam logic [1:0] c_st_wait    = 2'd1;
    localparam logic [1:0] c_st_stagger = 2'd2;
    localparam logic [1:0] c_st_run     = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [c_hold_w-1:0]     r_hold_cnt;
    logic [c_stag_w-1:0]     r_stag_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic                    r_req;
    logic [cord_width_p-1:0] r_cord;
    logic [num_router_p-1:0] r_reset;
    logic                    r_done;
    logic                    r_busy;

    logic                    w_req_set;
    logic                    w_req_clr;
    logic                    w_hold_last;
    logic                    w_stag_last;
    logic                    w_idx_last;
    logic                    w_accept_clr;
    logic                    w_stag_stay;
    logic [num_router_p-1:0] w_reset_next;
    logic                    w_done_next;
    logic                    w_busy_next;

    assign w_req_set    = req_v_i &  req_reset_i;
    assign w_req_clr    = req_v_i & ~req_reset_i;
    assign w_hold_last  = (r_hold_cnt == c_hold_last);
    assign w_stag_last  = (r_stag_cnt == c_stag_last);
    assign w_idx_last   = (r_idx == c_idx_last);
    // A reset=0 request only counts while the routers are still held.
    assign w_accept_clr = w_req_clr & ((r_state == c_st_hold) | (r_state == c_st_wait));
    assign w_stag_stay  = (r_state == c_st_stagger) & (w_state_next == c_st_stagger);

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= c_st_hold;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a reset=1 request overrides every state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_hold: begin
                if (w_hold_last) begin
                    w_state_next = (r_req & ~w_req_clr) ? c_st_wait : c_st_stagger;
                end
            end
            c_st_wait: begin
                if (w_req_clr) begin
                    w_state_next = c_st_stagger;
                end
            end
            c_st_stagger: begin
                if (w_stag_last && w_idx_last) begin
                    w_state_next = c_st_run;
                end
            end
            default: begin
                w_state_next = c_st_run;
            end
        endcase
        if (w_req_set) begin
            w_state_next = c_st_hold;
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_reset_next = '1;
        w_done_next  = (w_state_next == c_st_run);
        w_busy_next  = (w_state_next != c_st_run);
        case (w_state_next)
            c_st_stagger: begin
                if (r_state == c_st_stagger) begin
                    w_reset_next = r_reset;
                    if (w_stag_last) begin
                        for (int k = 0; k < num_router_p; k++) begin
                            if (int'(r_idx) == k) begin
                                w_reset_next[k] = 1'b0;
                            end
                        end
                    end
                end
            end
            c_st_run: begin
                w_reset_next = '0;
            end
            default: begin
                w_reset_next = '1;
            end
        endcase
    end

    // Counters, latched request and cord
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_hold_cnt <= '0;
            r_stag_cnt <= '0;
            r_idx      <= '0;
            r_req      <= 1'b1;
            r_cord     <= '0;
        end else begin
            if (w_req_set) begin
                r_req <= 1'b1;
            end else if (w_accept_clr) begin
                r_req <= 1'b0;
            end

            if (w_req_set || w_accept_clr) begin
                r_cord <= req_cord_i;
            end

            if ((w_state_next != c_st_hold) || w_req_set) begin
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            if (w_stag_stay && !w_stag_last) begin
                r_stag_cnt <= r_stag_cnt + 1'b1;
            end else begin
                r_stag_cnt <= '0;
            end

            if (!w_stag_stay) begin
                r_idx <= '0;
            end else if (w_stag_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_reset <= '1;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_reset <= w_reset_next;
            r_done  <= w_done_next;
            r_busy  <= w_busy_next;
        end
    end

    assign reset_o = r_reset;
    assign cord_o  = r_cord;
    assign done_o  = r_done;
    assign busy_o  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bsg_chip_router_reset_seq.sv
// ============================================================================
//  Module      : tb_bsg_chip_router_reset_seq
//  Description : Directed bench for the router reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_chip_router_reset_seq;

    logic       clk;
    logic       reset_n_i;
    logic       req_v_i;
    logic       req_reset_i;
    logic [6:0] req_cord_i;
    logic [4:0] reset_o;
    logic [6:0] cord_o;
    logic       done_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;   // index of the next rising edge with reset released

    bsg_chip_router_reset_seq #(
        .num_router_p       (5),
        .cord_width_p       (7),
        .min_reset_cycles_p (16),
        .stagger_cycles_p   (4)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n_i),
        .req_v_i     (req_v_i),
        .req_reset_i (req_reset_i),
        .req_cord_i  (req_cord_i),
        .reset_o     (reset_o),
        .cord_o      (cord_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        req_v_i = 1'b0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic send(input logic rst_lvl, input logic [6:0] cord);
        req_v_i     = 1'b1;
        req_reset_i = rst_lvl;
        req_cord_i  = cord;
    endtask

    // Holds reset for three edges; optionally drives a reset=0 request on the last one.
    task automatic do_reset(input bit with_req);
        reset_n_i = 1'b0;
        req_v_i   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        if (with_req) send(1'b0, 7'h44);
        @(posedge clk);
        #1;
        req_v_i   = 1'b0;
        reset_n_i = 1'b1;
        cyc       = 0;
    endtask

    initial begin
        reset_n_i   = 1'b0;
        req_v_i     = 1'b0;
        req_reset_i = 1'b0;
        req_cord_i  = '0;

        // Normal bring-up with early reset=0 request
        do_reset(1'b0);
        chk_eq("rst_reset_o", 32'(reset_o), 32'h1f);
        chk_eq("rst_cord_o",  32'(cord_o),  32'h00);
        chk_eq("rst_done_o",  32'(done_o),  32'h0);
        chk_eq("rst_busy_o",  32'(busy_o),  32'h1);
        run_to(2);
        send(1'b0, 7'h12);
        step();
        chk_eq("cord_load", 32'(cord_o), 32'h12);
        run_to(16);
        chk_eq("hold_end_reset", 32'(reset_o), 32'h1f);
        run_to(19);
        chk_eq("pre_rel0", 32'(reset_o), 32'h1f);
        run_to(20);
        chk_eq("rel0", 32'(reset_o), 32'h1e);
        run_to(24);
        chk_eq("rel1", 32'(reset_o), 32'h1c);
        run_to(28);
        chk_eq("rel2", 32'(reset_o), 32'h18);
        run_to(32);
        chk_eq("rel3", 32'(reset_o), 32'h10);
        run_to(35);
        chk_eq("pre_run_done", 32'(done_o), 32'h0);
        chk_eq("pre_run_busy", 32'(busy_o), 32'h1);
        run_to(36);
        chk_eq("run_reset", 32'(reset_o), 32'h00);
        chk_eq("run_done",  32'(done_o),  32'h1);
        chk_eq("run_busy",  32'(busy_o),  32'h0);

        // reset=0 request in RUN is ignored
        run_to(40);
        send(1'b0, 7'h33);
        step();
        chk_eq("ign_cord",  32'(cord_o),  32'h12);
        chk_eq("ign_reset", 32'(reset_o), 32'h00);
        chk_eq("ign_done",  32'(done_o),  32'h1);

        // reset=1 request in RUN
        run_to(45);
        send(1'b1, 7'h05);
        step();
        chk_eq("rerst_reset", 32'(reset_o), 32'h1f);
        chk_eq("rerst_cord",  32'(cord_o),  32'h05);
        chk_eq("rerst_done",  32'(done_o),  32'h0);
        chk_eq("rerst_busy",  32'(busy_o),  32'h1);
        // Hold spans 46..61; a reset=0 request in the final hold cycle goes straight to STAGGER
        run_to(61);
        send(1'b0, 7'h06);
        step();
        run_to(65);
        chk_eq("lasthold_pre", 32'(reset_o), 32'h1f);
        run_to(66);
        chk_eq("lasthold_rel0", 32'(reset_o), 32'h1e);
        run_to(70);
        chk_eq("mid_rel1", 32'(reset_o), 32'h1c);

        // reset=1 mid-STAGGER re-asserts all bits and restarts
        send(1'b1, 7'h0a);
        step();
        chk_eq("midstag_reset", 32'(reset_o), 32'h1f);
        chk_eq("midstag_cord",  32'(cord_o),  32'h0a);
        run_to(90);
        chk_eq("midstag_wait",  32'(reset_o), 32'h1f);
        chk_eq("midstag_busy",  32'(busy_o),  32'h1);
        run_to(95);
        send(1'b0, 7'h0b);
        step();
        run_to(99);
        chk_eq("restart_pre", 32'(reset_o), 32'h1f);
        run_to(100);
        chk_eq("restart_rel0", 32'(reset_o), 32'h1e);

        // No request after reset: WAIT indefinitely, then release on request
        do_reset(1'b0);
        run_to(16);
        chk_eq("wait_16", 32'(reset_o), 32'h1f);
        run_to(39);
        chk_eq("wait_39", 32'(reset_o), 32'h1f);
        chk_eq("wait_busy", 32'(busy_o), 32'h1);
        run_to(40);
        send(1'b0, 7'h21);
        step();
        chk_eq("wait_cord", 32'(cord_o), 32'h21);
        run_to(44);
        chk_eq("wait_pre_rel0", 32'(reset_o), 32'h1f);
        run_to(45);
        chk_eq("wait_rel0", 32'(reset_o), 32'h1e);

        // Request coincident with reset is dropped
        do_reset(1'b1);
        chk_eq("drop_cord", 32'(cord_o), 32'h00);
        run_to(20);
        chk_eq("drop_20", 32'(reset_o), 32'h1f);
        run_to(30);
        chk_eq("drop_30", 32'(reset_o), 32'h1f);
        chk_eq("drop_busy", 32'(busy_o), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
